// File: rtl/rtc_param_writer_if.sv
// Handshake between rtc_param_writer (master) and the low-level RTC bus controller (slave).
// One write transaction is bus_addr/bus_data qualified by bus_req and acknowledged by bus_done.
interface rtc_param_writer_if;
   logic       bus_req;
   logic [7:0] bus_addr;
   logic [7:0] bus_data;
   logic       bus_done;

   modport master (
      output bus_req,
      output bus_addr,
      output bus_data,
      input  bus_done
   );

   modport slave (
      input  bus_req,
      input  bus_addr,
      input  bus_data,
      output bus_done
   );
endinterface

// File: rtl/rtc_param_writer.sv
// Writes a snapshot of the nine user time/timer parameters to the RTC, then the transfer command,
// as ten sequential bus transactions guarded by a per-transaction watchdog.
module rtc_param_writer #(
   parameter logic [7:0]  ADDR_S   = 8'h21,
   parameter logic [7:0]  ADDR_M   = 8'h22,
   parameter logic [7:0]  ADDR_H   = 8'h23,
   parameter logic [7:0]  ADDR_D   = 8'h24,
   parameter logic [7:0]  ADDR_ME  = 8'h25,
   parameter logic [7:0]  ADDR_A   = 8'h26,
   parameter logic [7:0]  ADDR_ST  = 8'h41,
   parameter logic [7:0]  ADDR_MT  = 8'h42,
   parameter logic [7:0]  ADDR_HT  = 8'h43,
   parameter logic [7:0]  CMD_ADDR = 8'hF0,
   parameter logic [7:0]  CMD_DATA = 8'hF0,
   parameter int unsigned TIMEOUT  = 1023
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_start,
   input  logic [7:0]          a,
   input  logic [7:0]          me,
   input  logic [7:0]          d,
   input  logic [7:0]          h,
   input  logic [7:0]          m,
   input  logic [7:0]          s,
   input  logic [7:0]          ht,
   input  logic [7:0]          mt,
   input  logic [7:0]          st,
   rtc_param_writer_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic                error
);

   localparam int unsigned WdW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);
   localparam logic [3:0] LastIdx = 4'd9;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StGap,
      StFinish
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [WdW-1:0]   wdog_q, wdog_d, wdog_inc;
   logic [7:0]       shadow_q [9];
   logic [7:0]       shadow_d [9];
   logic             req_q, req_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [7:0]       tx_addr, tx_data;

   // Shadow slots are stored in transaction order: s, m, h, d, me, a, st, mt, ht.
   always_comb begin
      tx_addr = CMD_ADDR;
      tx_data = CMD_DATA;
      case (idx_q)
         4'd0: begin tx_addr = ADDR_S;  tx_data = shadow_q[0]; end
         4'd1: begin tx_addr = ADDR_M;  tx_data = shadow_q[1]; end
         4'd2: begin tx_addr = ADDR_H;  tx_data = shadow_q[2]; end
         4'd3: begin tx_addr = ADDR_D;  tx_data = shadow_q[3]; end
         4'd4: begin tx_addr = ADDR_ME; tx_data = shadow_q[4]; end
         4'd5: begin tx_addr = ADDR_A;  tx_data = shadow_q[5]; end
         4'd6: begin tx_addr = ADDR_ST; tx_data = shadow_q[6]; end
         4'd7: begin tx_addr = ADDR_MT; tx_data = shadow_q[7]; end
         4'd8: begin tx_addr = ADDR_HT; tx_data = shadow_q[8]; end
         default: ;
      endcase
   end

   assign wdog_inc = wdog_q + WdW'(1);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wdog_d   = wdog_q;
      shadow_d = shadow_q;
      req_d    = req_q;
      addr_d   = addr_q;
      data_d   = data_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      error_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (wr_start) begin
               shadow_d = '{s, m, h, d, me, a, st, mt, ht};
               idx_d    = '0;
               busy_d   = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            req_d   = 1'b1;
            addr_d  = tx_addr;
            data_d  = tx_data;
            wdog_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            // An acknowledge in the final watchdog cycle still completes the transaction.
            if (bus.bus_done) begin
               req_d = 1'b0;
               if (idx_q == LastIdx) begin
                  state_d = StFinish;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StGap;
               end
            end else if (wdog_inc == WdMax) begin
               wdog_d  = wdog_inc;
               error_d = 1'b1;
               req_d   = 1'b0;
               busy_d  = 1'b0;
               idx_d   = '0;
               state_d = StIdle;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         StGap: begin
            state_d = StIssue;
         end
         StFinish: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         wdog_q   <= '0;
         shadow_q <= '{default: '0};
         req_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wdog_q   <= wdog_d;
         shadow_q <= shadow_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.bus_req  = req_q;
   assign bus.bus_addr = addr_q;
   assign bus.bus_data = data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule
